// File: rtl/iob_regfile_sp_ctrl_pkg.sv
// Shared types and encodings for the iob_regfile_sp request front-end.
package iob_regfile_sp_ctrl_pkg;

  localparam int unsigned STATE_W = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Request-type encodings carried on req_we_i
  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

endpackage

// File: rtl/iob_regfile_sp_ctrl_sweep.sv
// Clear sequencer: IDLE/CLEAR FSM plus an ADDR_W sweep counter.
// Ports:
//   clk_i, rst_n_i  clock, synchronous active-low reset
//   cke_i           clock enable; all state holds when low
//   start_i         start a sweep (sampled only in IDLE)
//   addr_o          current sweep address
//   busy_o          high while in CLEAR
//   done_o          one-cycle pulse in the first IDLE cycle after a sweep
module iob_regfile_sp_ctrl_sweep
  import iob_regfile_sp_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cke_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              last_c;

  // Last address is detected before the counter wraps
  assign last_c = (cnt_q == {ADDR_W{1'b1}});

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (cke_i) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
          end
        end
        ST_CLEAR: begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (last_c) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign addr_o = cnt_q;
  assign busy_o = (state_q == ST_CLEAR);
  assign done_o = done_q;

endmodule

// File: rtl/iob_regfile_sp_ctrl.sv
// Valid/ready front-end for iob_regfile_sp: serialises single-beat reads and
// writes onto the single regfile port, returns read data through a one-entry
// registered response buffer, and runs a zero-fill clear sweep.
// Optional macro IOB_REGFILE_SP_CTRL_WRITE_ACK_EN: writes also return a
// response carrying the written data.
// Ports:
//   clk_i, rst_n_i, cke_i        clock, synchronous active-low reset, enable
//   req_*                        request channel (valid/ready, we, addr, wdata)
//   rsp_*                        response channel (valid/ready, rdata)
//   clear_i, busy_o, done_o      clear sweep control/status
//   rf_we_o, rf_addr_o, rf_d_o   regfile write port (combinational)
//   rf_d_i                       regfile combinational read data
module iob_regfile_sp_ctrl
  import iob_regfile_sp_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cke_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_d_o,
  input  logic [DATA_W-1:0] rf_d_i
);

  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_busy;
  logic              accept_c;
  logic              load_c;
  logic [DATA_W-1:0] load_data_c;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  iob_regfile_sp_ctrl_sweep #(
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .cke_i   (cke_i),
    .start_i (clear_i),
    .addr_o  (sweep_addr),
    .busy_o  (sweep_busy),
    .done_o  (done_o)
  );

  // Request arbitration and regfile port drive; reset blocks all regfile writes
  always_comb begin
    req_ready_o = 1'b0;
    accept_c    = 1'b0;
    rf_we_o     = 1'b0;
    rf_addr_o   = '0;
    rf_d_o      = '0;
    if (rst_n_i && cke_i) begin
      if (sweep_busy) begin
        rf_we_o   = 1'b1;
        rf_addr_o = sweep_addr;
      end else begin
        req_ready_o = ~clear_i & (~rsp_valid_q | rsp_ready_i);
        accept_c    = req_valid_i & req_ready_o;
        if (accept_c) begin
          rf_addr_o = req_addr_i;
          if (req_we_i == REQ_WR) begin
            rf_we_o = 1'b1;
            rf_d_o  = req_wdata_i;
          end
        end
      end
    end
  end

  // Response buffer fill source
  always_comb begin
`ifdef IOB_REGFILE_SP_CTRL_WRITE_ACK_EN
    load_c      = accept_c;
    load_data_c = (req_we_i == REQ_WR) ? req_wdata_i : rf_d_i;
`else
    load_c      = accept_c & (req_we_i == REQ_RD);
    load_data_c = rf_d_i;
`endif
  end

  // One-entry response buffer; a refill wins over a drain in the same cycle
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (cke_i) begin
      if (load_c) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= load_data_c;
      end else if (rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign busy_o      = sweep_busy;

endmodule

// File: tb/tb_iob_regfile_sp_ctrl.sv
// Self-checking bench for iob_regfile_sp_ctrl with a behavioural regfile.
module tb_iob_regfile_sp_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
`ifdef IOB_REGFILE_SP_CTRL_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              cke_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              clear_i;
  logic              busy_o;
  logic              done_o;
  logic              rf_we_o;
  logic [ADDR_W-1:0] rf_addr_o;
  logic [DATA_W-1:0] rf_d_o;
  logic [DATA_W-1:0] rf_d_i;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] rf_mem  [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  always #5 clk_i = ~clk_i;

  // Behavioural iob_regfile_sp
  always @(posedge clk_i) if (rf_we_o) rf_mem[rf_addr_o] <= rf_d_o;
  assign rf_d_i = rf_mem[rf_addr_o];

  iob_regfile_sp_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cke_i(cke_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .clear_i(clear_i), .busy_o(busy_o), .done_o(done_o),
    .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_d_o(rf_d_o), .rf_d_i(rf_d_i)
  );

  // Drive one request at the falling edge; it is accepted at the next posedge
  task automatic issue(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_wdata_i = d; rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) begin
      exp_mem[i] = $urandom;
      issue(1'b1, ADDR_W'(i), exp_mem[i]);
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; cke_i = 1'b1; clear_i = 1'b1; rsp_ready_i = 1'b1;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 4'd5; req_wdata_i = $urandom;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      cke_i = (c == 0);
      #1;
      checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL rst_rf_we[%0d]: got %b want 0", c, rf_we_o); end
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready[%0d]: got %b want 0", c, req_ready_o); end
      @(posedge clk_i);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1; cke_i = 1'b1; clear_i = 1'b0; req_valid_i = 1'b0;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid_o); end
    checks++; if (rsp_rdata_o !== '0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata_o); end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b want 00", busy_o, done_o); end
    checks++; if (rf_we_o !== 1'b0 || rf_addr_o !== '0 || rf_d_o !== '0) begin
      errors++; $display("FAIL rst_rf_port: got we=%b addr=%h d=%h want 0/0/0", rf_we_o, rf_addr_o, rf_d_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_idle_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = ADDR_W'(i); req_wdata_i = DATA_W'(i + 32); rsp_ready_i = 1'b1;
      #1;
      checks++; if (req_ready_o !== 1'b1 || rf_we_o !== 1'b1 || rf_addr_o !== ADDR_W'(i) || rf_d_o !== DATA_W'(i + 32)) begin
        errors++; $display("FAIL wr_port[%0d]: got rdy=%b we=%b addr=%h d=%h want 1/1/%h/%h", i, req_ready_o, rf_we_o, rf_addr_o, rf_d_o, i, i + 32); end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      exp_mem[i] = DATA_W'(i + 32);
`ifdef IOB_REGFILE_SP_CTRL_WRITE_ACK_EN
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_mem[i]) begin
        errors++; $display("FAIL wr_ack[%0d]: got v=%b d=%h want 1/%h", i, rsp_valid_o, rsp_rdata_o, exp_mem[i]); end
`else
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wr_norsp[%0d]: got %b want 0", i, rsp_valid_o); end
`endif
    end
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, ADDR_W'(i), '0);
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_mem[i]) begin
        errors++; $display("FAIL rd[%0d]: got v=%b d=%h want 1/%h", i, rsp_valid_o, rsp_rdata_o, exp_mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] last;
    for (int i = 0; i < DEPTH; i++) begin
      a = ADDR_W'($urandom_range(0, DEPTH - 1));
      issue(1'b0, a, '0);
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_mem[a]) begin
        errors++; $display("FAIL b2b_rd[%0d]: got v=%b d=%h want 1/%h", i, rsp_valid_o, rsp_rdata_o, exp_mem[a]); end
    end
    last = exp_mem[a];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = a ^ 4'hF; rsp_ready_i = 1'b0;
      #1;
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", c, req_ready_o); end
      @(posedge clk_i); #1;
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== last) begin
        errors++; $display("FAIL stall_hold[%0d]: got v=%b d=%h want 1/%h", c, rsp_valid_o, rsp_rdata_o, last); end
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL drain: got %b want 0", rsp_valid_o); end
    a = ADDR_W'($urandom_range(0, DEPTH - 1));
    d = $urandom;
    issue(1'b1, a, d);
    exp_mem[a] = d;
    issue(1'b0, a, '0);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== d) begin
      errors++; $display("FAIL raw: got v=%b d=%h want 1/%h", rsp_valid_o, rsp_rdata_o, d); end
  endtask

  task automatic test_random();
    bit m_valid;
    logic [DATA_W-1:0] m_data;
    bit v, we, rr, exp_ready;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    @(negedge clk_i);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    m_valid = 1'b0; m_data = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_i);
      v = $urandom_range(0, 3) != 0; we = $urandom_range(0, 1) == 1; rr = $urandom_range(0, 2) != 0;
      a = ADDR_W'($urandom_range(0, DEPTH - 1)); d = $urandom;
      req_valid_i = v; req_we_i = we; req_addr_i = a; req_wdata_i = d; rsp_ready_i = rr;
      #1;
      exp_ready = !m_valid || rr;
      checks++; if (req_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready_o, exp_ready); end
      if (v && exp_ready && (!we || WACK)) begin
        m_valid = 1'b1;
        m_data  = we ? d : exp_mem[a];
      end else if (rr) begin
        m_valid = 1'b0;
      end
      if (v && exp_ready && we) exp_mem[a] = d;
      @(posedge clk_i); #1;
      checks++; if (rsp_valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, rsp_valid_o, m_valid); end
      if (m_valid) begin
        checks++; if (rsp_rdata_o !== m_data) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", c, rsp_rdata_o, m_data); end
      end
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_clear();
    fill_random();
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 4'd2; rsp_ready_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    clear_i = 1'b1; req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 4'd9; req_wdata_i = $urandom;
    #1;
    checks++; if (req_ready_o !== 1'b0 || rf_we_o !== 1'b0) begin
      errors++; $display("FAIL clr_prio: got rdy=%b we=%b want 0/0", req_ready_o, rf_we_o); end
    @(posedge clk_i); #1;
    clear_i = 1'b0; req_valid_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk_i);
      if (k == 1) rsp_ready_i = 1'b1;
      #1;
      checks++; if (busy_o !== 1'b1 || rf_we_o !== 1'b1 || rf_addr_o !== ADDR_W'(k) || rf_d_o !== '0 || req_ready_o !== 1'b0) begin
        errors++; $display("FAIL clr_step[%0d]: got busy=%b we=%b addr=%h d=%h rdy=%b want 1/1/%h/0/0", k, busy_o, rf_we_o, rf_addr_o, rf_d_o, req_ready_o, k); end
      if (k == 0) begin
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_mem[2]) begin
          errors++; $display("FAIL clr_pending: got v=%b d=%h want 1/%h", rsp_valid_o, rsp_rdata_o, exp_mem[2]); end
      end
      if (k == 2) begin
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL clr_drain: got %b want 0", rsp_valid_o); end
      end
      @(posedge clk_i); #1;
    end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL clr_done: got busy=%b done=%b want 0/1", busy_o, done_o); end
    @(posedge clk_i); #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL clr_done_pulse: got %b want 0", done_o); end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, ADDR_W'(i), '0);
      checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_mem[i]) begin
        errors++; $display("FAIL clr_rd[%0d]: got v=%b d=%h want 1/%h", i, rsp_valid_o, rsp_rdata_o, exp_mem[i]); end
    end
  endtask

  task automatic test_cke_pause();
    fill_random();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 5) begin
        for (int p = 0; p < 4; p++) begin
          @(negedge clk_i);
          cke_i = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b1;
          #1;
          checks++; if (rf_we_o !== 1'b0 || req_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL cke_hold[%0d]: got we=%b rdy=%b busy=%b want 0/0/1", p, rf_we_o, req_ready_o, busy_o); end
          @(posedge clk_i); #1;
        end
        cke_i = 1'b1; req_valid_i = 1'b0;
      end
      @(negedge clk_i); #1;
      checks++; if (rf_we_o !== 1'b1 || rf_addr_o !== ADDR_W'(k)) begin
        errors++; $display("FAIL cke_step[%0d]: got we=%b addr=%h want 1/%h", k, rf_we_o, rf_addr_o, k); end
      @(posedge clk_i); #1;
    end
    checks++; if (busy_o !== 1'b0 || done_o !== 1'b1) begin errors++; $display("FAIL cke_done: got busy=%b done=%b want 0/1", busy_o, done_o); end
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, ADDR_W'(i), '0);
      checks++; if (rsp_rdata_o !== exp_mem[i]) begin errors++; $display("FAIL cke_rd[%0d]: got %h want %h", i, rsp_rdata_o, exp_mem[i]); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    fill_random();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_i); #1;
      checks++; if (rf_addr_o !== ADDR_W'(k)) begin errors++; $display("FAIL rstsw_step[%0d]: got %h want %h", k, rf_addr_o, k); end
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL rstsw_we: got %b want 0", rf_we_o); end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i); #1;
      checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++; $display("FAIL rstsw_nodone[%0d]: got done=%b busy=%b want 0/0", c, done_o, busy_o); end
    end
    for (int i = 0; i < 7; i++) exp_mem[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 7) begin
        issue(1'b0, ADDR_W'(i), '0);
        checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_mem[i]) begin
          errors++; $display("FAIL rstsw_rd[%0d]: got v=%b d=%h want 1/%h", i, rsp_valid_o, rsp_rdata_o, exp_mem[i]); end
      end
    end
  endtask

  task automatic test_write_ack();
    issue(1'b1, 4'd3, 32'hA5A5_A5A5);
    exp_mem[3] = 32'hA5A5_A5A5;
`ifdef IOB_REGFILE_SP_CTRL_WRITE_ACK_EN
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL wack: got v=%b d=%h want 1/a5a5a5a5", rsp_valid_o, rsp_rdata_o); end
`else
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL wack_none: got %b want 0", rsp_valid_o); end
`endif
    issue(1'b0, 4'd3, '0);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== exp_mem[3]) begin
      errors++; $display("FAIL wack_rd: got v=%b d=%h want 1/%h", rsp_valid_o, rsp_rdata_o, exp_mem[3]); end
  endtask

  initial begin
    rst_n_i = 1'b0; cke_i = 1'b1; clear_i = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b1;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_clear();
    test_cke_pause();
    test_reset_mid_sweep();
    test_write_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
